// File: rtl/fix_tx_pkg.sv
// Shared constants and trailer-detector state encoding for the FIX transmit buffer.
package fix_tx_pkg;

  localparam logic [7:0] SOH    = 8'h01;
  localparam logic [7:0] CH_1   = 8'h31;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_EQ  = 8'h3D;
  localparam logic [7:0] DIG_LO = 8'h30;
  localparam logic [7:0] DIG_HI = 8'h39;

  typedef enum logic [2:0] {
    W_BODY,
    W_SOH,
    W_ONE,
    W_ZERO,
    W_EQ,
    W_D1,
    W_D2,
    W_D3
  } trl_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= DIG_LO) && (b <= DIG_HI);
  endfunction

endpackage

// File: rtl/fix_trailer_detect.sv
// Recognises the <SOH>10=ddd<SOH> checksum trailer on the accepted write stream.
// commit_o pulses combinationally with the strobe of the closing SOH.
module fix_trailer_detect
  import fix_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       strobe_i,
  output logic       commit_o
);

  trl_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= W_BODY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (strobe_i) begin
      // After three digits only SOH is meaningful, and it ends the message.
      if (state_q == W_D3) begin
        state_d = W_BODY;
      end else if (byte_i == SOH) begin
        state_d = W_SOH;
      end else begin
        state_d = W_BODY;
        case (state_q)
          W_SOH:  if (byte_i == CH_1)     state_d = W_ONE;
          W_ONE:  if (byte_i == CH_0)     state_d = W_ZERO;
          W_ZERO: if (byte_i == CH_EQ)    state_d = W_EQ;
          W_EQ:   if (is_digit(byte_i))   state_d = W_D1;
          W_D1:   if (is_digit(byte_i))   state_d = W_D2;
          W_D2:   if (is_digit(byte_i))   state_d = W_D3;
          default: state_d = W_BODY;
        endcase
      end
    end
  end

  always_comb begin
    commit_o = strobe_i && (state_q == W_D3) && (byte_i == SOH);
  end

endmodule

// File: rtl/fix_tx_buffer.sv
// Store-and-forward FIX byte buffer: only complete messages are released to the TOE.
// Show-ahead read side; writes are dropped (sticky overflow) while full.
module fix_tx_buffer
  import fix_tx_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_data_i,
  output logic        full_o,
  output logic [AW:0] level_o,
  output logic [AW:0] msg_count_o,
  output logic        overflow_o,
  output logic        toe_valid_o,
  input  logic        toe_ready_i,
  output logic [7:0]  toe_data_o,
  output logic        toe_sop_o,
  output logic        toe_eop_o
);

  localparam int PW = AW + 1;

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] msg_cnt_q, msg_cnt_d;
  logic        sop_pend_q, sop_pend_d;
  logic        ovf_q, ovf_d;

  logic        wr_acc;
  logic        commit;
  logic        rd_hs;
  logic        eop_hs;
  logic [8:0]  rd_word;

  fix_trailer_detect u_trailer (
    .clk      (clk),
    .rst      (rst),
    .byte_i   (wr_data_i),
    .strobe_i (wr_acc),
    .commit_o (commit)
  );

  assign level_o     = wr_ptr_q - rd_ptr_q;
  assign full_o      = (level_o == PW'(DEPTH));
  assign msg_count_o = msg_cnt_q;
  assign overflow_o  = ovf_q;

  assign wr_acc  = wr_en_i && !full_o;
  assign rd_word = mem[rd_ptr_q[AW-1:0]];

  // Array contents are only meaningful while a committed message is present.
  assign toe_valid_o = (msg_cnt_q != '0);
  assign toe_data_o  = rd_word[7:0];
  assign toe_eop_o   = toe_valid_o && rd_word[8];
  assign toe_sop_o   = toe_valid_o && sop_pend_q;

  assign rd_hs  = toe_valid_o && toe_ready_i;
  assign eop_hs = rd_hs && rd_word[8];

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= {commit, wr_data_i};
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d   = rd_ptr_q + PW'(rd_hs);
    msg_cnt_d  = msg_cnt_q + PW'(commit) - PW'(eop_hs);
    sop_pend_d = rd_hs ? rd_word[8] : sop_pend_q;
    ovf_d      = ovf_q || (wr_en_i && full_o);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      msg_cnt_q  <= '0;
      sop_pend_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      msg_cnt_q  <= msg_cnt_d;
      sop_pend_q <= sop_pend_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fix_tx_buffer.sv
// Bench for fix_tx_buffer: a cycle table plus directed sequences against a byte scoreboard.
module tb_fix_tx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic       full_o;
  logic [8:0] level_o;
  logic [8:0] msg_count_o;
  logic       overflow_o;
  logic       toe_valid_o;
  logic       toe_ready_i;
  logic [7:0] toe_data_o;
  logic       toe_sop_o;
  logic       toe_eop_o;

  fix_tx_buffer #(.DEPTH(256)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en_i),
    .wr_data_i   (wr_data_i),
    .full_o      (full_o),
    .level_o     (level_o),
    .msg_count_o (msg_count_o),
    .overflow_o  (overflow_o),
    .toe_valid_o (toe_valid_o),
    .toe_ready_i (toe_ready_i),
    .toe_data_o  (toe_data_o),
    .toe_sop_o   (toe_sop_o),
    .toe_eop_o   (toe_eop_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  string MSG1 = "8=FIX.4.2|9=5|35=0|10=161|";

  logic [7:0] txq[$];
  logic [7:0] exp_dat[$];
  logic       exp_sop[$];
  logic       exp_eop[$];

  typedef struct {
    logic       wen;
    logic [7:0] wd;
    logic       rdy;
    logic       v, s, e;
    logic [7:0] d;
    logic [8:0] lvl, mc;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic wen, input logic [7:0] wd, input logic rdy,
                              input logic v, input logic s, input logic e,
                              input logic [7:0] d, input int lvl, input int mc);
    vec_t r;
    r.wen = wen; r.wd = wd; r.rdy = rdy;
    r.v = v; r.s = s; r.e = e; r.d = d;
    r.lvl = 9'(lvl); r.mc = 9'(mc);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // '|' stands for SOH; bytes go to the send queue and the expected-output scoreboard.
  function automatic void add_msg(input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] b;
      b = (s[i] == "|") ? 8'h01 : s[i];
      txq.push_back(b);
      exp_dat.push_back(b);
      exp_sop.push_back(i == 0);
      exp_eop.push_back(i == s.len() - 1);
    end
  endfunction

  task automatic send(input bit chk_nv);
    while (txq.size() != 0) begin
      if (chk_nv) begin
        chk("pre_commit_vld", toe_valid_o, 0);
        chk("pre_commit_mc", msg_count_o, 0);
      end
      wr_en_i   = 1'b1;
      wr_data_i = txq.pop_front();
      @(negedge clk);
    end
    wr_en_i = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n = 0;
    logic pst = 1'b0;
    logic [7:0] pd = 8'h00;
    logic ps = 1'b0, pe = 1'b0;
    while (exp_dat.size() != 0 && n < budget) begin
      if (pst) begin
        chk("stall_vld", toe_valid_o, 1);
        chk("stall_dat", toe_data_o, pd);
        chk("stall_sop", toe_sop_o, ps);
        chk("stall_eop", toe_eop_o, pe);
      end
      toe_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (toe_valid_o && toe_ready_i) begin
        chk("out_dat", toe_data_o, exp_dat.pop_front());
        chk("out_sop", toe_sop_o, exp_sop.pop_front());
        chk("out_eop", toe_eop_o, exp_eop.pop_front());
      end
      pst = toe_valid_o && !toe_ready_i;
      pd = toe_data_o; ps = toe_sop_o; pe = toe_eop_o;
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_dat.size(), 0);
    toe_ready_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_full"}, full_o, 0);
    chk({tag, "_level"}, level_o, 0);
    chk({tag, "_mc"}, msg_count_o, 0);
    chk({tag, "_ovf"}, overflow_o, 0);
    chk({tag, "_vld"}, toe_valid_o, 0);
    chk({tag, "_sop"}, toe_sop_o, 0);
    chk({tag, "_eop"}, toe_eop_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; wr_en_i = 1'b0; wr_data_i = 8'h00; toe_ready_i = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    // Two 9-byte messages: second written while first drains; commit and eop handshake coincide at row 17.
    tbl[0]  = mk(1, 8'h58, 1, 0, 0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 8'h01, 1, 0, 0, 0, 8'h00, 1, 0);
    tbl[2]  = mk(1, 8'h31, 1, 0, 0, 0, 8'h00, 2, 0);
    tbl[3]  = mk(1, 8'h30, 1, 0, 0, 0, 8'h00, 3, 0);
    tbl[4]  = mk(1, 8'h3D, 1, 0, 0, 0, 8'h00, 4, 0);
    tbl[5]  = mk(1, 8'h30, 1, 0, 0, 0, 8'h00, 5, 0);
    tbl[6]  = mk(1, 8'h30, 1, 0, 0, 0, 8'h00, 6, 0);
    tbl[7]  = mk(1, 8'h37, 1, 0, 0, 0, 8'h00, 7, 0);
    tbl[8]  = mk(1, 8'h01, 1, 0, 0, 0, 8'h00, 8, 0);
    tbl[9]  = mk(1, 8'h58, 1, 1, 1, 0, 8'h58, 9, 1);
    tbl[10] = mk(1, 8'h01, 1, 1, 0, 0, 8'h01, 9, 1);
    tbl[11] = mk(1, 8'h31, 1, 1, 0, 0, 8'h31, 9, 1);
    tbl[12] = mk(1, 8'h30, 1, 1, 0, 0, 8'h30, 9, 1);
    tbl[13] = mk(1, 8'h3D, 1, 1, 0, 0, 8'h3D, 9, 1);
    tbl[14] = mk(1, 8'h30, 1, 1, 0, 0, 8'h30, 9, 1);
    tbl[15] = mk(1, 8'h30, 1, 1, 0, 0, 8'h30, 9, 1);
    tbl[16] = mk(1, 8'h37, 1, 1, 0, 0, 8'h37, 9, 1);
    tbl[17] = mk(1, 8'h01, 1, 1, 0, 1, 8'h01, 9, 1);
    tbl[18] = mk(0, 8'h00, 1, 1, 1, 0, 8'h58, 9, 1);
    tbl[19] = mk(0, 8'h00, 1, 1, 0, 0, 8'h01, 8, 1);
    tbl[20] = mk(0, 8'h00, 1, 1, 0, 0, 8'h31, 7, 1);
    tbl[21] = mk(0, 8'h00, 1, 1, 0, 0, 8'h30, 6, 1);
    tbl[22] = mk(0, 8'h00, 1, 1, 0, 0, 8'h3D, 5, 1);
    tbl[23] = mk(0, 8'h00, 1, 1, 0, 0, 8'h30, 4, 1);
    tbl[24] = mk(0, 8'h00, 1, 1, 0, 0, 8'h30, 3, 1);
    tbl[25] = mk(0, 8'h00, 1, 1, 0, 0, 8'h37, 2, 1);
    tbl[26] = mk(0, 8'h00, 1, 1, 0, 1, 8'h01, 1, 1);
    tbl[27] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);

    for (int i = 0; i < 28; i++) begin
      chk($sformatf("tbl%0d_vld", i), toe_valid_o, tbl[i].v);
      chk($sformatf("tbl%0d_sop", i), toe_sop_o, tbl[i].s);
      chk($sformatf("tbl%0d_eop", i), toe_eop_o, tbl[i].e);
      chk($sformatf("tbl%0d_lvl", i), level_o, tbl[i].lvl);
      chk($sformatf("tbl%0d_mc", i), msg_count_o, tbl[i].mc);
      chk($sformatf("tbl%0d_full", i), full_o, 0);
      if (tbl[i].v) chk($sformatf("tbl%0d_dat", i), toe_data_o, tbl[i].d);
      wr_en_i = tbl[i].wen; wr_data_i = tbl[i].wd; toe_ready_i = tbl[i].rdy;
      @(negedge clk);
    end
    wr_en_i = 1'b0; toe_ready_i = 1'b0;

    // Single 26-byte message, nothing visible until the closing SOH is written.
    add_msg(MSG1);
    toe_ready_i = 1'b1;
    send(1);
    chk("msg1_mc", msg_count_o, 1);
    chk("msg1_vld", toe_valid_o, 1);
    chk("msg1_sop", toe_sop_o, 1);
    chk("msg1_lvl", level_o, 26);
    drain(0, 100);
    chk("msg1_mc_after", msg_count_o, 0);
    chk("msg1_lvl_after", level_o, 0);

    // False trailers inside the body must not commit.
    add_msg("35=A|58=x|10=ab|58=y|10=1234|10=077|");
    send(0);
    chk("false_trl_mc", msg_count_o, 1);
    chk("false_trl_lvl", level_o, 36);
    drain(0, 100);
    chk("false_trl_mc_after", msg_count_o, 0);

    // Two messages held back, then released.
    add_msg(MSG1);
    add_msg(MSG1);
    send(0);
    chk("two_mc", msg_count_o, 2);
    chk("two_lvl", level_o, 52);
    chk("two_sop", toe_sop_o, 1);
    drain(0, 100);
    chk("two_mc_after", msg_count_o, 0);

    // Concurrent writing and randomly stalled reading.
    add_msg(MSG1);
    add_msg("35=D|11=7|10=000|");
    add_msg(MSG1);
    fork
      send(0);
      drain(1, 2000);
    join
    chk("rand_mc_after", msg_count_o, 0);
    chk("rand_lvl_after", level_o, 0);

    // Fill to capacity, then overflow.
    for (int i = 0; i < 255; i++) txq.push_back(8'h41);
    send(0);
    chk("fill255_full", full_o, 0);
    chk("fill255_lvl", level_o, 255);
    txq.push_back(8'h41);
    send(0);
    chk("fill256_full", full_o, 1);
    chk("fill256_lvl", level_o, 256);
    chk("fill256_ovf", overflow_o, 0);
    chk("fill256_mc", msg_count_o, 0);
    txq.push_back(8'h41);
    send(0);
    chk("ovf_set", overflow_o, 1);
    chk("ovf_lvl", level_o, 256);
    chk("ovf_full", full_o, 1);
    @(negedge clk);
    chk("ovf_sticky", overflow_o, 1);

    // Asynchronous reset clears everything, including a half-seen trailer.
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst1");
    @(negedge clk);
    rst = 1'b1;
    txq.push_back(8'h58);
    txq.push_back(8'h01); txq.push_back(8'h31); txq.push_back(8'h30);
    txq.push_back(8'h3D); txq.push_back(8'h31); txq.push_back(8'h32);
    send(0);
    chk("partial_lvl", level_o, 7);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst2");
    @(negedge clk);
    rst = 1'b1;
    add_msg({"3|", MSG1});
    send(0);
    chk("post_rst_mc", msg_count_o, 1);
    chk("post_rst_sop", toe_sop_o, 1);
    drain(0, 100);
    chk("post_rst_mc_after", msg_count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
